// File: rtl/usr_seq.sv
// Sequencer for the universal shift register: loads a word, issues len shift
// modes in the chosen direction and presents the shifted-out bit stream.
module usr_seq #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_len,
    input  logic [WIDTH-1:0] usr_out,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       sum,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] SUM_HOLD  = 2'b00;
    localparam logic [1:0] SUM_LEFT  = 2'b01;
    localparam logic [1:0] SUM_RIGHT = 2'b10;
    localparam logic [1:0] SUM_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [1:0]       sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] len_clamped_c;

    // A length of zero or beyond the register width means a full-word transfer.
    always_comb begin
        len_clamped_c = in_len;
        if (in_len == '0 || in_len > CNT_W'(WIDTH)) begin
            len_clamped_c = CNT_W'(WIDTH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            sum_q   <= SUM_HOLD;
            count_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sum_d   = sum_q;
        count_d = count_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                sum_d = SUM_HOLD;
                if (in_valid) begin
                    q_d     = in_data;
                    dir_d   = in_dir;
                    count_d = len_clamped_c;
                    sum_d   = SUM_LOAD;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sum_d   = dir_q ? SUM_LEFT : SUM_RIGHT;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    sum_d   = SUM_HOLD;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                sum_d   = SUM_HOLD;
                state_d = S_IDLE;
            end
            default: begin
                sum_d   = SUM_HOLD;
                state_d = S_IDLE;
            end
        endcase
    end

    // Status decoded from registered state only; in_valid never reaches these.
    always_comb begin
        in_ready  = (state_q == S_IDLE) && reset;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        ser_valid = (state_q == S_SHIFT);
        ser_out   = 1'b0;
        if (state_q == S_SHIFT) begin
            ser_out = dir_q ? usr_out[WIDTH-1] : usr_out[0];
        end
    end

    assign q   = q_q;
    assign sum = sum_q;

endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq paired with a behavioural universal shift register.
module tb_usr_seq;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_dir = 1'b0;
    logic [CNT_W-1:0] in_len = '0;
    logic [WIDTH-1:0] usr_out;
    logic [WIDTH-1:0] q;
    logic [1:0]       sum;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_err = 0;

    usr_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_len    (in_len),
        .usr_out   (usr_out),
        .q         (q),
        .sum       (sum),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Universal shift register driven by the sequencer, sharing its reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            usr_out <= '0;
        end else begin
            case (sum)
                2'b01:   usr_out <= {usr_out[WIDTH-2:0], 1'b0};
                2'b10:   usr_out <= {1'b0, usr_out[WIDTH-1:1]};
                2'b11:   usr_out <= q;
                default: usr_out <= usr_out;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " ready"}, 32'(in_ready), 32'd1);
    endtask

    // One transfer; exp_bits holds the emitted stream with the first bit at index 0.
    task automatic xfer(input string tag, input logic [3:0] data, input logic dir,
                        input logic [2:0] len, input logic [3:0] exp_bits,
                        input int exp_n, input logic [3:0] exp_reg);
        logic [3:0] got = '0;
        int         n = 0;
        bit         seen_done = 1'b0;
        wait_ready(tag);
        in_valid = 1'b1;
        in_data  = data;
        in_dir   = dir;
        in_len   = len;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~data;
        in_dir   = ~dir;
        in_len   = 3'd1;
        check({tag, " load sum"}, 32'(sum), 32'd3);
        check({tag, " load busy"}, 32'(busy), 32'd1);
        check({tag, " load q"}, 32'(q), 32'(data));
        for (int c = 0; c < 12 && !seen_done; c++) begin
            @(posedge clk);
            #1;
            if (ser_valid) begin
                if (n == 0) check({tag, " shift sum"}, 32'(sum), dir ? 32'd1 : 32'd2);
                if (n < 4) got[n] = ser_out;
                n++;
            end
            if (done) seen_done = 1'b1;
        end
        check({tag, " done seen"}, 32'(seen_done), 32'd1);
        check({tag, " bit count"}, 32'(n), 32'(exp_n));
        check({tag, " bits"}, 32'(got), 32'(exp_bits));
        check({tag, " usr_out"}, 32'(usr_out), 32'(exp_reg));
        check({tag, " done sum"}, 32'(sum), 32'd0);
    endtask

    initial begin
        int loads;
        int first_cyc;
        int second_cyc;
        int nser;
        int dones;
        logic [7:0] stream;

        // Power-on reset
        #12;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst q", 32'(q), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle in_ready", 32'(in_ready), 32'd1);
        check("idle sum", 32'(sum), 32'd0);

        xfer("right4", 4'b1011, 1'b0, 3'd4, 4'b1011, 4, 4'b0000);
        xfer("left2", 4'b1011, 1'b1, 3'd2, 4'b0001, 2, 4'b1100);
        xfer("clamp0", 4'b0110, 1'b1, 3'd0, 4'b0110, 4, 4'b0000);
        xfer("clamp7", 4'b1001, 1'b0, 3'd7, 4'b1001, 4, 4'b0000);
        xfer("left3", 4'b1101, 1'b1, 3'd3, 4'b0011, 3, 4'b1000);
        xfer("right1", 4'b0010, 1'b0, 3'd1, 4'b0000, 1, 4'b0001);

        // Reset asserted in the middle of SHIFT
        wait_ready("rstshift");
        in_valid = 1'b1; in_data = 4'b1011; in_dir = 1'b0; in_len = 3'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstshift pre valid", 32'(ser_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstshift busy", 32'(busy), 32'd0);
        check("rstshift done", 32'(done), 32'd0);
        check("rstshift ser_valid", 32'(ser_valid), 32'd0);
        check("rstshift ser_out", 32'(ser_out), 32'd0);
        check("rstshift sum", 32'(sum), 32'd0);
        check("rstshift q", 32'(q), 32'd0);
        check("rstshift in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstshift rel ready", 32'(in_ready), 32'd1);
        check("rstshift rel sum", 32'(sum), 32'd0);

        // Reset pulse while in LOAD
        wait_ready("rstload");
        in_valid = 1'b1; in_data = 4'b1111; in_dir = 1'b1; in_len = 3'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstload in load", 32'(sum), 32'd3);
        reset = 1'b0;
        #2 reset = 1'b1;
        nser = 0;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ser_valid) nser++;
            if (done) dones++;
        end
        check("rstload ser_valid", 32'(nser), 32'd0);
        check("rstload done", 32'(dones), 32'd0);
        xfer("after_rst", 4'b0100, 1'b1, 3'd2, 4'b0010, 2, 4'b0000);

        // in_valid held high across two words
        wait_ready("hold");
        in_valid = 1'b1; in_data = 4'hA; in_dir = 1'b0; in_len = 3'd0;
        loads = 0; first_cyc = 0; second_cyc = 0; nser = 0; dones = 0; stream = '0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (sum == 2'b11) begin
                loads++;
                if (loads == 1) begin
                    first_cyc = c;
                    check("hold q first", 32'(q), 32'hA);
                    in_data = 4'hF;
                end else if (loads == 2) begin
                    second_cyc = c;
                    in_valid = 1'b0;
                end
            end
            if (ser_valid) begin
                if (nser < 8) stream[nser] = ser_out;
                nser++;
                if (nser == 2) in_data = 4'h5;
            end
            if (done) dones++;
        end
        check("hold loads", 32'(loads), 32'd2);
        check("hold spacing", 32'(second_cyc - first_cyc), 32'd7);
        check("hold bits count", 32'(nser), 32'd8);
        check("hold stream", 32'(stream), 32'h5A);
        check("hold dones", 32'(dones), 32'd2);
        check("hold q last", 32'(q), 32'h5);
        check("hold final sum", 32'(sum), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
